// File: rtl/esn_reservoir_seq.sv
// Echo-state-network reservoir update engine, time-multiplexed onto one MAC.
// Computes x[t+1] = act(W*x[t] + Win*u[t]) one product per cycle, row by row,
// into a shadow buffer; the visible state only changes on the commit cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   w_we/w_row/w_col/   run-time weight write; w_col==N addresses Win[row]
//   w_data
//   w_err               one-cycle pulse: last write was dropped
//   clear_state         zero the state vector (IDLE only, beats u_valid)
//   u_valid/u_ready/    input sample handshake
//   u_data
//   x_valid             one-cycle pulse: x_state holds a fresh state
//   x_state             neuron i at [i*DW +: DW]
//   busy                update in progress
module esn_reservoir_seq #(
  parameter int N    = 7,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int ACT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic [$clog2(N)-1:0]     w_row,
  input  logic [$clog2(N+1)-1:0]   w_col,
  input  logic [DW-1:0]            w_data,
  output logic                     w_err,
  input  logic                     clear_state,
  input  logic                     u_valid,
  output logic                     u_ready,
  input  logic [DW-1:0]            u_data,
  output logic                     x_valid,
  output logic [N*DW-1:0]          x_state,
  output logic                     busy
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N+1);
  // Sum of N+1 full-width products cannot overflow this width.
  localparam int AW = 2*DW + CW;

  localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] CLIP_MAX = AW'(1) << FRAC;
  localparam logic signed [AW-1:0] CLIP_MIN = -CLIP_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_COMMIT} state_e;

  state_e                  state_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic signed [AW-1:0]    acc_q;
  logic [DW-1:0]           u_q;
  logic [N-1:0][DW-1:0]    x_q;
  logic [N-1:0][DW-1:0]    shadow_q;
  logic                    x_valid_q;
  logic                    w_err_q;

  // Weight store: row-major, column N holds the input weight. Not reset.
  logic signed [DW-1:0]    w_mem [N][N+1];

  logic                    w_ok;
  logic signed [DW-1:0]    op;
  logic signed [DW-1:0]    wt;
  logic signed [2*DW-1:0]  prod;
  logic signed [AW-1:0]    sum_d;
  logic signed [AW-1:0]    shifted;
  logic [DW-1:0]           act_d;

  assign w_ok = (state_q == S_IDLE) && (int'(w_row) < N) && (int'(w_col) <= N);

  always_ff @(posedge clk) begin
    if (w_we && w_ok) w_mem[w_row][w_col] <= w_data;
  end

  // Operand mux: old state for recurrent columns, latched sample for column N.
  always_comb begin
    op = $signed(u_q);
    for (int i = 0; i < N; i++)
      if (col_q == CW'(i)) op = $signed(x_q[i]);
  end

  assign wt      = w_mem[row_q][col_q];
  assign prod    = op * wt;
  assign sum_d   = acc_q + {{CW{prod[2*DW-1]}}, prod};
  assign shifted = sum_d >>> FRAC;  // floor toward -inf

  always_comb begin
    act_d = shifted[DW-1:0];
    if (ACT == 1) begin
      if (shifted > CLIP_MAX)      act_d = CLIP_MAX[DW-1:0];
      else if (shifted < CLIP_MIN) act_d = CLIP_MIN[DW-1:0];
    end else begin
      if (shifted > SAT_MAX)       act_d = SAT_MAX[DW-1:0];
      else if (shifted < SAT_MIN)  act_d = SAT_MIN[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      acc_q     <= '0;
      u_q       <= '0;
      x_q       <= '0;
      shadow_q  <= '0;
      x_valid_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      x_valid_q <= 1'b0;
      w_err_q   <= w_we && !w_ok;
      case (state_q)
        S_IDLE: begin
          if (clear_state) begin
            x_q <= '0;
          end else if (u_valid) begin
            u_q     <= u_data;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (col_q == CW'(N)) begin
            for (int i = 0; i < N; i++)
              if (row_q == RW'(i)) shadow_q[i] <= act_d;
            acc_q <= '0;
            col_q <= '0;
            if (row_q == RW'(N-1)) state_q <= S_COMMIT;
            else                   row_q   <= row_q + 1'b1;
          end else begin
            acc_q <= sum_d;
            col_q <= col_q + 1'b1;
          end
        end
        S_COMMIT: begin
          x_q       <= shadow_q;
          x_valid_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign u_ready = (state_q == S_IDLE) && !clear_state;
  assign busy    = (state_q != S_IDLE);
  assign x_valid = x_valid_q;
  assign w_err   = w_err_q;
  assign x_state = x_q;

endmodule

// File: tb/tb_esn_reservoir_seq.sv
// Bench for esn_reservoir_seq: two instances (saturate and clip activation)
// share all stimulus; a scoreboard model predicts each committed state.
module tb_esn_reservoir_seq;
  localparam int N = 2, DW = 16, FRAC = 8;

  logic             clk = 1'b0, rst = 1'b1;
  logic             w_we = 1'b0, clear_state = 1'b0, u_valid = 1'b0;
  logic [0:0]       w_row = '0;
  logic [1:0]       w_col = '0;
  logic [DW-1:0]    w_data = '0, u_data = '0;
  logic             w_err0, u_ready0, x_valid0, busy0;
  logic             w_err1, u_ready1, x_valid1, busy1;
  logic [N*DW-1:0]  x_state0, x_state1;

  esn_reservoir_seq #(.N(N), .DW(DW), .FRAC(FRAC), .ACT(0)) dut0 (
    .clk(clk), .rst(rst), .w_we(w_we), .w_row(w_row), .w_col(w_col),
    .w_data(w_data), .w_err(w_err0), .clear_state(clear_state),
    .u_valid(u_valid), .u_ready(u_ready0), .u_data(u_data),
    .x_valid(x_valid0), .x_state(x_state0), .busy(busy0));

  esn_reservoir_seq #(.N(N), .DW(DW), .FRAC(FRAC), .ACT(1)) dut1 (
    .clk(clk), .rst(rst), .w_we(w_we), .w_row(w_row), .w_col(w_col),
    .w_data(w_data), .w_err(w_err1), .clear_state(clear_state),
    .u_valid(u_valid), .u_ready(u_ready1), .u_data(u_data),
    .x_valid(x_valid1), .x_state(x_state1), .busy(busy1));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0, acc_edge = 0;
  always @(posedge clk) cyc <= cyc + 1;

  shortint     mw [N][N+1];
  shortint     mx [2][N];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic shortint act_f(input longint s, input int a);
    longint hi = (a == 1) ? 256 : 32767;
    longint lo = (a == 1) ? -256 : -32768;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return shortint'(s);
  endfunction

  task automatic model_step(input logic [15:0] u);
    shortint nx [2][N];
    shortint su = shortint'(u);
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < N; i++) begin
        longint acc = 0;
        for (int j = 0; j < N; j++) acc += longint'(mw[i][j]) * longint'(mx[a][j]);
        acc += longint'(mw[i][N]) * longint'(su);
        nx[a][i] = act_f(acc >>> FRAC, a);
      end
    mx = nx;
    q0.push_back({nx[0][1], nx[0][0]});
    q1.push_back({nx[1][1], nx[1][0]});
  endtask

  task automatic model_clear();
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < N; i++) mx[a][i] = 0;
  endtask

  // Scoreboard: every x_valid pops one prediction per instance.
  always @(negedge clk) begin
    if (x_valid0) begin
      if (q0.size() == 0) chk("xv0_unexpected", 1, 0);
      else chk("sb_act0", x_state0, q0.pop_front());
    end
    if (x_valid1) begin
      if (q1.size() == 0) chk("xv1_unexpected", 1, 0);
      else chk("sb_act1", x_state1, q1.pop_front());
    end
  end

  task automatic wr(input int row, input int col, input logic [15:0] d, input bit exp_err);
    @(negedge clk);
    w_we = 1'b1; w_row = 1'(row); w_col = 2'(col); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    chk("w_err0", w_err0, exp_err);
    chk("w_err1", w_err1, exp_err);
    if (!exp_err) mw[row][col] = shortint'(d);
  endtask

  task automatic accept_u(input logic [15:0] u);
    int t = 0;
    @(negedge clk);
    while (!u_ready0 && t < 200) begin @(negedge clk); t++; end
    if (!u_ready0) chk("accept_timeout", 0, 1);
    else begin
      u_valid = 1'b1; u_data = u;
      model_step(u);
      @(negedge clk);
      acc_edge = cyc;
      u_valid = 1'b0;
      chk("busy_after_accept", busy0, 1);
    end
  endtask

  task automatic wait_xv(input bit check_lat);
    int t = 0;
    while (!x_valid0 && t < 200) begin @(negedge clk); t++; end
    if (!x_valid0) chk("xv_timeout", 0, 1);
    else begin
      if (check_lat) chk("latency", cyc - acc_edge, 7);
      chk("xv1_sync", x_valid1, 1);
      @(negedge clk);
      chk("xv_one_cycle", x_valid0, 0);
    end
  endtask

  initial begin
    int t1, t2;
    bit seen;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x0", x_state0, 0);
    chk("rst_x1", x_state1, 0);
    chk("rst_ready", u_ready0, 1);
    chk("rst_xvalid", x_valid0, 0);
    chk("rst_busy", busy0, 0);

    // Diagonal recurrent weights 0.5, input weights +1 / -1
    wr(0, 0, 16'h0080, 0); wr(0, 1, 16'h0000, 0); wr(0, 2, 16'h0100, 0);
    wr(1, 0, 16'h0000, 0); wr(1, 1, 16'h0080, 0); wr(1, 2, 16'hFF00, 0);
    accept_u(16'h0100); wait_xv(1);
    chk("basic_u1", x_state0, 32'hFF000100);
    accept_u(16'h0000); wait_xv(1);
    chk("basic_u0", x_state0, 32'hFF800080);

    // u_valid held high: two accepts 8 cycles apart
    @(negedge clk);
    u_valid = 1'b1; u_data = 16'h0040;
    model_step(16'h0040);
    t1 = cyc + 1; t2 = t1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_ready0) begin model_step(16'h0040); t2 = cyc + 1; break; end
    end
    @(negedge clk);
    u_valid = 1'b0;
    chk("b2b_spacing", t2 - t1, 8);
    wait_xv(0);

    // Write while busy is dropped; result uses the old weight
    accept_u(16'h0100);
    wr(0, 0, 16'h7000, 1);
    wait_xv(1);

    // Column index beyond Win
    wr(0, 3, 16'h1234, 1);

    // clear_state beats u_valid
    @(negedge clk);
    clear_state = 1'b1; u_valid = 1'b1; u_data = 16'h0100;
    #1 chk("clr_ready", u_ready0, 0);
    @(negedge clk);
    clear_state = 1'b0; u_valid = 1'b0;
    chk("clr_busy", busy0, 0);
    chk("clr_x0", x_state0, 0);
    chk("clr_x1", x_state1, 0);
    model_clear();

    // Saturation / clipping
    wr(0, 0, 16'h0000, 0); wr(0, 1, 16'h0000, 0); wr(0, 2, 16'h7FFF, 0);
    accept_u(16'h7FFF); wait_xv(1);
    chk("sat_pos_act0", x_state0[15:0], 16'h7FFF);
    chk("sat_pos_act1", x_state1[15:0], 16'h0100);
    wr(0, 2, 16'h8000, 0);
    accept_u(16'h7FFF); wait_xv(1);
    chk("sat_neg_act0", x_state0[15:0], 16'h8000);
    chk("sat_neg_act1", x_state1[15:0], 16'hFF00);

    // Floor rounding of negative results
    @(negedge clk); clear_state = 1'b1;
    @(negedge clk); clear_state = 1'b0;
    model_clear();
    wr(0, 0, 16'h0080, 0); wr(0, 2, 16'h0001, 0);
    accept_u(16'hFFFF); wait_xv(1);
    chk("floor_pre", x_state0[15:0], 16'hFFFF);
    accept_u(16'h0000); wait_xv(1);
    chk("floor_act0", x_state0[15:0], 16'hFFFF);
    chk("floor_act1", x_state1[15:0], 16'hFFFF);

    // Reset mid-update: aborted, nothing committed
    @(negedge clk);
    u_valid = 1'b1; u_data = 16'h0100;
    @(negedge clk);
    u_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("abort_busy", busy0, 0);
    chk("abort_x0", x_state0, 0);
    chk("abort_x1", x_state1, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen |= x_valid0 | x_valid1;
    end
    chk("abort_no_xvalid", seen, 0);
    chk("sb_drained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
